// File: rtl/fetch_unit.sv
// Instruction fetch stage: FETCH/WAIT/HOLD sequencer with a one-cycle memory
// latency, a valid/ready handshake to decode, and redirect on control transfers.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] instruction_n, instr_pc_n, fetch_count_n;
  logic            instr_valid_n;

  assign imem_address = pc;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      instr_pc    <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_valid <= instr_valid_n;
      instruction <= instruction_n;
      instr_pc    <= instr_pc_n;
      fetch_count <= fetch_count_n;
    end
  end

  // Next-state logic; a redirect overrides sequencing but a same-edge
  // handshake in HOLD still counts the consumed instruction.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_valid_n = instr_valid;
    instruction_n = instruction;
    instr_pc_n    = instr_pc;
    fetch_count_n = fetch_count;

    case (state)
      S_FETCH: state_n = S_WAIT;
      S_WAIT: begin
        instruction_n = imem_data_out;
        instr_pc_n    = pc;
        instr_valid_n = 1'b1;
        state_n       = S_HOLD;
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_n          = pc + XLEN'(4);
          fetch_count_n = fetch_count + XLEN'(1);
          instr_valid_n = 1'b0;
          instruction_n = NOP_INSTR;
          state_n       = S_FETCH;
        end
      end
      default: state_n = S_FETCH;
    endcase

    if (redirect_valid) begin
      pc_n          = redirect_pc & ~XLEN'(3);
      instr_valid_n = 1'b0;
      instruction_n = NOP_INSTR;
      state_n       = S_FETCH;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected presentations, a
// monitor pops and checks each one (and its stability while held).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_data_out = 32'h0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_address  (imem_address),
    .imem_data_out (imem_data_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0050_0093;
    return a ^ 32'h1357_2468;
  endfunction

  // Synchronous instruction memory: data one cycle after the address
  always @(posedge clk) imem_data_out <= mem_word(imem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.instr = mem_word(a);
    e.pc    = a;
    exp_q.push_back(e);
  endtask

  // Monitor: one pop per presentation, then stability while held
  exp_t cur;
  bit   seen = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (instr_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", instr_pc, 32'hxxxx_xxxx);
        end else begin
          cur = exp_q.pop_front();
          chk("instr", instruction, cur.instr);
          chk("instr_pc", instr_pc, cur.pc);
        end
        seen = 1'b1;
      end else begin
        chk("hold_instr", instruction, cur.instr);
        chk("hold_pc", instr_pc, cur.pc);
      end
    end else begin
      seen = 1'b0;
    end
  end

  initial begin
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, NOP);
    chk("rst_instr_pc", instr_pc, 32'h1000);
    chk("rst_addr", imem_address, 32'h1000);
    chk("rst_count", fetch_count, 32'd0);
    step(2);
    reset = 1'b0;

    // Basic fetch with ready tied high
    instr_ready = 1'b1;
    push(32'h1000);
    step(1);
    chk("t1_addr_wait", imem_address, 32'h1000);
    step(1);
    chk("t1_valid_edge2", {31'b0, instr_valid}, 32'd1);
    step(1);
    chk("t1_next_addr", imem_address, 32'h1004);
    chk("t1_count", fetch_count, 32'd1);
    chk("t1_valid_low", {31'b0, instr_valid}, 32'd0);

    // Backpressure for five HOLD cycles
    instr_ready = 1'b0;
    push(32'h1004);
    step(2);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_valid", {31'b0, instr_valid}, 32'd1);
      chk("bp_addr", imem_address, 32'h1004);
      chk("bp_count", fetch_count, 32'd1);
    end
    instr_ready = 1'b1;
    step(1);
    chk("bp_next_addr", imem_address, 32'h1008);
    chk("bp_count_after", fetch_count, 32'd2);

    // Redirect in WAIT to an unaligned target
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2002;
    step(1);
    redirect_valid = 1'b0;
    chk("rw_addr", imem_address, 32'h2000);
    chk("rw_count", fetch_count, 32'd2);
    chk("rw_valid", {31'b0, instr_valid}, 32'd0);
    chk("rw_instr_nop", instruction, NOP);

    // Redirect coincident with handshake in HOLD
    instr_ready = 1'b0;
    push(32'h2000);
    step(2);
    chk("rh_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1100;
    step(1);
    redirect_valid = 1'b0;
    chk("rh_count", fetch_count, 32'd3);
    chk("rh_addr", imem_address, 32'h1100);

    // Redirect in FETCH, low bits ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step(1);
    redirect_valid = 1'b0;
    chk("rf_addr", imem_address, 32'hFFFF_FFFC);
    chk("rf_count", fetch_count, 32'd3);

    // pc wrap on accept
    push(32'hFFFF_FFFC);
    step(3);
    chk("wrap_addr", imem_address, 32'h0000_0000);
    chk("wrap_count", fetch_count, 32'd4);

    // Asynchronous reset while holding
    instr_ready = 1'b0;
    push(32'h0000_0000);
    step(2);
    chk("ar_pre_valid", {31'b0, instr_valid}, 32'd1);
    #5;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'b0, instr_valid}, 32'd0);
    chk("ar_addr", imem_address, 32'h1000);
    chk("ar_count", fetch_count, 32'd0);
    chk("ar_instr", instruction, NOP);
    #1;
    reset = 1'b0;

    // Fetch resumes from RESET_PC after release
    instr_ready = 1'b1;
    push(32'h1000);
    step(3);
    chk("post_addr", imem_address, 32'h1004);
    chk("post_count", fetch_count, 32'd1);

    step(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h1000, giving the first instruction address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h00000013, giving the instruction value held while nothing valid is presented.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port imem_address, output, 32 bits: instruction memory read address.
REQ-006 The block SHALL have port imem_data_out, input, 32 bits: instruction memory read data, valid one cycle after the address.
REQ-007 The block SHALL have port instr_valid, output, 1 bit: instruction and instr_pc hold a fetched instruction.
REQ-008 The block SHALL have port instr_ready, input, 1 bit: the decode/execute stage accepts the instruction.
REQ-009 The block SHALL have port instruction, output, 32 bits: fetched instruction word.
REQ-010 The block SHALL have port instr_pc, output, 32 bits: address of the fetched instruction.
REQ-011 The block SHALL have port redirect_valid, input, 1 bit: request to fetch from redirect_pc next (jal, jalr, taken branch).
REQ-012 The block SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-013 The block SHALL have port fetch_count, output, 32 bits: count of accepted instructions.

Function
REQ-014 The block SHALL implement three states:
- FETCH: present pc on imem_address.
- WAIT: capture imem_data_out.
- HOLD: present the instruction downstream.
REQ-015 imem_address SHALL equal the internal pc register combinationally in every state.
REQ-016 FETCH SHALL always transition to WAIT on the next edge unless redirect_valid is high.
REQ-017 In WAIT, on the edge, instruction SHALL load imem_data_out, instr_pc SHALL load pc, instr_valid SHALL go 1, and the state SHALL move to HOLD.
REQ-018 In HOLD, instr_valid SHALL stay 1 and instruction/instr_pc SHALL stay stable until an edge with instr_ready=1.
REQ-019 An edge in HOLD with instr_ready=1 and redirect_valid=0 SHALL:
- set pc to pc+4 and fetch_count to fetch_count+1;
- set instr_valid to 0 and instruction to NOP_INSTR;
- move the state to FETCH.
REQ-020 Minimum issue interval SHALL be 3 cycles: FETCH, WAIT, HOLD with instr_ready already high.
REQ-021 An edge with redirect_valid=1 in any state SHALL:
- set pc to {redirect_pc[31:2],2'b00};
- set instr_valid to 0 and instruction to NOP_INSTR;
- move the state to FETCH;
- discard any in-flight memory data.
REQ-022 Redirect and handshake on the same HOLD edge SHALL increment fetch_count, because the instruction is consumed, and SHALL load pc from the redirect, because the redirect takes priority over pc+4.
REQ-023 Redirect in FETCH or WAIT SHALL NOT increment fetch_count.
REQ-024 pc+4 SHALL wrap modulo 2^32: 32'hFFFFFFFC advances to 32'h00000000.
REQ-025 fetch_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-026 instr_ready while instr_valid=0 SHALL have no effect.
REQ-027 redirect_pc bits [1:0] SHALL be ignored, with no error raised.

Reset
REQ-028 Asserting reset SHALL immediately, without waiting for a clock edge, set:
- pc=RESET_PC, with imem_address=RESET_PC;
- state=FETCH;
- instr_valid=0, instruction=NOP_INSTR, instr_pc=RESET_PC;
- fetch_count=0.
REQ-029 Reset asserted mid-operation, including in HOLD with instr_valid=1, SHALL drop the pending instruction without counting it.
REQ-030 The first FETCH cycle SHALL begin on the first rising edge after reset deasserts.

Verification
REQ-031 Reset release, instr_ready tied 1, memory returning 32'h00500093 at 0x1000 -> instr_valid rises on the 2nd edge with instruction=32'h00500093 and instr_pc=0x1000; the next FETCH presents 0x1004; fetch_count=1.
REQ-032 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instruction/instr_pc/instr_valid unchanged for all 5 cycles; imem_address stays at the held pc; pc advances only after instr_ready=1.
REQ-033 Redirect in WAIT to 32'h2002 -> the returned data is not presented; the next FETCH address is 32'h2000; fetch_count unchanged.
REQ-034 Redirect coincident with handshake in HOLD to 0x1100 -> fetch_count increments by 1; next imem_address=0x1100, not pc+4.
REQ-035 Wrap: redirect to 32'hFFFFFFFC, then accept -> next fetch address is 32'h00000000.
REQ-036 Asynchronous reset asserted between edges while in HOLD -> instr_valid=0, imem_address=0x1000 and fetch_count=0 before the next edge.
